// File: rtl/trng_pkg.sv
// Shared types and defaults for the TRNG conditioning path.
package trng_pkg;

    typedef enum logic [0:0] {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } deb_state_t;

    localparam int DEF_POOL_DEPTH  = 16;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_SAMPLE_DIV  = 4;
    localparam int DEF_RCT_CUTOFF  = 32;

    // Occupancy needs one extra bit so that "full" is distinguishable from "empty".
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_bit_pool.sv
// Single-bit FIFO holding debiased bits; flush empties it, head is the oldest bit.
module trng_bit_pool
    import trng_pkg::*;
#(
    parameter  int DEPTH = DEF_POOL_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             push_bit,
    input  logic             pop,
    input  logic             flush,
    output logic             head,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    // A pop on an empty pool is ignored; a push into a full pool only lands if a pop frees a slot.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count defines which entries are valid and the top masks head when empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_bit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/trng_conditioner.sv
// Raw entropy synchroniser, sample divider, von Neumann debiaser and bit pool feeding the TRNG read port.
// Define TRNG_HEALTH_EN to add the repetition-count health test (health_fail is tied 0 otherwise).
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int POOL_DEPTH  = DEF_POOL_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int SAMPLE_DIV  = DEF_SAMPLE_DIV,
    parameter int RCT_CUTOFF  = DEF_RCT_CUTOFF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        raw_bit,
    input  logic                        trng_req,
    output logic                        trng_bit,
    output logic                        trng_avail,
    output logic [$clog2(POOL_DEPTH):0] pool_count,
    output logic                        underflow,
    input  logic                        fail_clr,
    output logic                        health_fail
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    if (POOL_DEPTH < 2 || (POOL_DEPTH & (POOL_DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        SAMPLE_DIV < 1 || RCT_CUTOFF < 2) begin : g_param_check
        $error("trng_conditioner: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_bit;
    logic [DIV_W-1:0]       div_cnt;
    logic                   strobe;
    deb_state_t             state;
    logic                   a_bit;
    logic                   push;
    logic                   halt;
    logic                   health_set;
    logic                   req_q;
    logic                   pop;
    logic                   head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
        end
    end

    assign s_bit = sync_q[SYNC_STAGES-1];

    // The strobe marks the cycle in which the divider wraps back to 0.
    assign strobe = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= strobe ? '0 : div_cnt + DIV_W'(1);
        end
    end

    assign halt = health_fail | health_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FIRST;
            a_bit <= 1'b0;
        end else if (halt) begin
            state <= ST_FIRST;
        end else if (strobe) begin
            case (state)
                ST_FIRST: begin
                    a_bit <= s_bit;
                    state <= ST_SECOND;
                end
                default: state <= ST_FIRST;
            endcase
        end
    end

    assign push = strobe && (state == ST_SECOND) && (a_bit != s_bit) && !halt;

`ifdef TRNG_HEALTH_EN
    localparam int RUN_W = $clog2(RCT_CUTOFF + 1);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             prev_sample;
    logic             fail_q;

    // A zero run count means no sample has been seen since reset or the last clear.
    always_comb begin
        // NOTE: default first so every path assigns run_next and no latch is inferred.
        run_next = RUN_W'(1);
        if (run_cnt != '0 && s_bit == prev_sample) begin
            run_next = (run_cnt == RUN_W'(RCT_CUTOFF)) ? run_cnt : run_cnt + RUN_W'(1);
        end
    end

    assign health_set = strobe && !fail_q && (run_next == RUN_W'(RCT_CUTOFF));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_cnt     <= '0;
            prev_sample <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            if (fail_q) begin
                if (fail_clr) begin
                    run_cnt <= '0;
                end
            end else if (strobe) begin
                run_cnt     <= run_next;
                prev_sample <= s_bit;
            end
            fail_q <= health_set | (fail_q & ~fail_clr);
        end
    end

    assign health_fail = fail_q;
`else
    assign health_set  = 1'b0;
    assign health_fail = 1'b0;
`endif

    assign pop = trng_req & ~req_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q     <= 1'b0;
            underflow <= 1'b0;
        end else begin
            req_q     <= trng_req;
            underflow <= (pop && pool_count == '0) | (underflow & ~fail_clr);
        end
    end

    trng_bit_pool #(
        .DEPTH (POOL_DEPTH)
    ) u_pool (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_bit (a_bit),
        .pop      (pop),
        .flush    (halt),
        .head     (head),
        .count    (pool_count)
    );

    assign trng_avail = (pool_count != '0) & ~health_fail;
    assign trng_bit   = trng_avail & head;

endmodule

// File: tb/tb_trng_conditioner.sv
// Self-checking bench for trng_conditioner against a queue-based reference model (SAMPLE_DIV=1).
module tb_trng_conditioner;

    localparam int DEPTH = 16;
    localparam int SYNC  = 2;
    localparam int CUT   = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic       raw_bit;
    logic       trng_req;
    logic       fail_clr;
    logic       trng_bit;
    logic       trng_avail;
    logic [4:0] pool_count;
    logic       underflow;
    logic       health_fail;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    trng_conditioner #(
        .POOL_DEPTH  (DEPTH),
        .SYNC_STAGES (SYNC),
        .SAMPLE_DIV  (1),
        .RCT_CUTOFF  (CUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .raw_bit     (raw_bit),
        .trng_req    (trng_req),
        .trng_bit    (trng_bit),
        .trng_avail  (trng_avail),
        .pool_count  (pool_count),
        .underflow   (underflow),
        .fail_clr    (fail_clr),
        .health_fail (health_fail)
    );

    // Reference model: sample delay line, pairing flag, bit queue, sticky flags, sample history.
    bit sync_m[$];
    bit pool_m[$];
    bit hist_m[$];
    bit have_a;
    bit a_val;
    bit prev_req;
    bit m_uf;
    bit m_hf;
    bit ph;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sync_m.delete();
        for (int i = 0; i < SYNC; i++) sync_m.push_back(1'b0);
        pool_m.delete();
        hist_m.delete();
        have_a   = 1'b0;
        a_val    = 1'b0;
        prev_req = 1'b0;
        m_uf     = 1'b0;
        m_hf     = 1'b0;
    endtask

    task automatic model_edge(input bit raw, input bit req, input bit clr);
        bit sample, pop_now, uf_set, hf_set, same;
        sample = sync_m.pop_front();
        sync_m.push_back(raw);
        pop_now  = req && !prev_req;
        prev_req = req;
        uf_set   = pop_now && (pool_m.size() == 0);
        if (pop_now && pool_m.size() != 0) void'(pool_m.pop_front());
        hf_set = 1'b0;
        if (!m_hf) begin
            if (have_a) begin
                if (a_val != sample && pool_m.size() < DEPTH) pool_m.push_back(a_val);
                have_a = 1'b0;
            end else begin
                a_val  = sample;
                have_a = 1'b1;
            end
`ifdef TRNG_HEALTH_EN
            hist_m.push_back(sample);
            if (hist_m.size() > CUT) void'(hist_m.pop_front());
            same = 1'b1;
            foreach (hist_m[i]) if (hist_m[i] != sample) same = 1'b0;
            hf_set = same && (hist_m.size() == CUT);
`else
            same = 1'b0;
`endif
        end
        if (hf_set) begin
            pool_m.delete();
            have_a = 1'b0;
        end
        m_uf = uf_set || (m_uf && !clr);
        if (m_hf && clr) begin
            m_hf = 1'b0;
            hist_m.delete();
        end
        if (hf_set) m_hf = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        bit exp_avail;
        exp_avail = (pool_m.size() != 0) && !m_hf;
        check({tag, "_count"}, 32'(pool_count), 32'(pool_m.size()));
        check({tag, "_avail"}, 32'(trng_avail), 32'(exp_avail));
        check({tag, "_bit"}, 32'(trng_bit), exp_avail ? 32'(pool_m[0]) : 32'd0);
        check({tag, "_uf"}, 32'(underflow), 32'(m_uf));
        check({tag, "_hf"}, 32'(health_fail), 32'(m_hf));
    endtask

    // One clock: drive inputs after the falling edge, advance the model at the rising edge, compare at the next falling edge.
    task automatic step(input bit raw, input bit req, input bit clr);
        raw_bit  = raw;
        trng_req = req;
        fail_clr = clr;
        @(posedge clk);
        model_edge(raw, req, clr);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic alt_step(input bit req, input bit clr);
        ph = ~ph;
        step(ph, req, clr);
    endtask

    task automatic drain_to(input int target);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 40 && pool_m.size() > target; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("drain_count", 32'(pool_count), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("rst");
        reset = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev_head;
        bit aligned;
        bit tp1[12];
        tp1 = '{0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0};
        reset    = 1'b1;
        raw_bit  = 1'b0;
        trng_req = 1'b0;
        fail_clr = 1'b0;
        ph       = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        reset = 1'b0;

        // Pairs 01,10,00,11,01 after the two reset-zero samples
        foreach (tp1[i]) step(tp1[i], 1'b0, 1'b0);
        check("tp1_count", 32'(pool_count), 32'd3);
        check("tp1_avail", 32'(trng_avail), 32'd1);
        check("tp1_head", 32'(trng_bit), 32'd0);

        // Fill past capacity; oldest bit stays at the head
        repeat (44) alt_step(1'b0, 1'b0);
        check("full_count", 32'(pool_count), 32'd16);
        check("full_head", 32'(trng_bit), 32'd0);
        check("full_uf", 32'(underflow), 32'd0);

        // Pop on the same edge as a push while full
        aligned = 1'b0;
        for (int i = 0; i < 8 && !aligned; i++) begin
            if (have_a && sync_m[0] != a_val && pool_m.size() == DEPTH) begin
                alt_step(1'b1, 1'b0);
                aligned = 1'b1;
                check("full_pushpop", 32'(pool_count), 32'd16);
            end else begin
                alt_step(1'b0, 1'b0);
            end
        end
        check("full_align", 32'(aligned), 32'd1);

        // Held request pops exactly once, pre-pop head visible in the rise cycle
        drain_to(3);
        prev_head = pool_m[0];
        trng_req  = 1'b1;
        #1;
        check("rise_bit", 32'(trng_bit), 32'(prev_head));
        @(posedge clk);
        model_edge(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_outputs("rise");
        repeat (4) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("hold_count", 32'(pool_count), 32'd2);

        // Underflow on an empty pool, sticky until fail_clr
        drain_to(0);
        step(1'b0, 1'b1, 1'b0);
        check("uf_bit", 32'(trng_bit), 32'd0);
        check("uf_set", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("uf_sticky", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check("uf_clr", 32'(underflow), 32'd0);
        step(1'b0, 1'b0, 1'b0);

        // Pop on the same edge as a push while empty
        aligned = 1'b0;
        for (int i = 0; i < 10 && !aligned; i++) begin
            if (have_a && sync_m[0] != a_val && pool_m.size() == 0) begin
                alt_step(1'b1, 1'b0);
                aligned = 1'b1;
                check("empty_pushpop", 32'(pool_count), 32'd1);
                check("empty_pushpop_uf", 32'(underflow), 32'd1);
            end else begin
                alt_step(1'b0, 1'b0);
            end
        end
        check("empty_align", 32'(aligned), 32'd1);
        alt_step(1'b0, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset in the middle of a pair with five bits pooled
        drain_to(0);
        for (int i = 0; i < 40 && pool_m.size() < 5; i++) alt_step(1'b0, 1'b0);
        alt_step(1'b0, 1'b0);
        check("pre_rst_count", 32'(pool_count), 32'd5);
        check("pre_rst_midpair", 32'(have_a), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(pool_count), 32'd0);
        check("arst_avail", 32'(trng_avail), 32'd0);
        check("arst_bit", 32'(trng_bit), 32'd0);
        check("arst_uf", 32'(underflow), 32'd0);
        check("arst_hf", 32'(health_fail), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end

`ifdef TRNG_HEALTH_EN
        do_reset();
        repeat (20) alt_step(1'b0, 1'b0);
        check("hf_prefill", 32'(pool_count != 0), 32'd1);
        repeat (40) step(1'b1, 1'b0, 1'b0);
        check("hf_set", 32'(health_fail), 32'd1);
        check("hf_count", 32'(pool_count), 32'd0);
        check("hf_avail", 32'(trng_avail), 32'd0);
        check("hf_bit", 32'(trng_bit), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        check("hf_clr", 32'(health_fail), 32'd0);
        repeat (20) alt_step(1'b0, 1'b0);
        check("hf_resume", 32'(pool_count != 0), 32'd1);
        check("hf_resume_flag", 32'(health_fail), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trng_conditioner.md
Name: trng_conditioner

Overview:
- Upstream stage feeding the memory-mapped TRNG read port.
- Synchronises the raw ring-oscillator bit, whitens it with a von Neumann debiaser, and buffers the debiased bits in a small bit pool.
- Serves one bit per request to the read port on its trng_req/trng_bit pair.
- The read port always completes in one cycle, so this block always drives a defined trng_bit and flags whether the bit was valid.

Parameters:
- POOL_DEPTH, 16, capacity of the debiased bit pool in bits (power of two, ≥2).
- SYNC_STAGES, 2, flops in the raw-input synchroniser (≥2).
- SAMPLE_DIV, 4, clk cycles between raw samples (≥1).
- RCT_CUTOFF, 32, repetition-count health-test cutoff (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- raw_bit  in  1  asynchronous entropy-source output.
- trng_req  in  1  read request from the TRNG read port; level, held ≥1 cycle per access.
- trng_bit  out  1  current pool head; 0 when empty or failed.
- trng_avail  out  1  pool non-empty and no health failure.
- pool_count  out  $clog2(POOL_DEPTH)+1  bits currently held.
- underflow  out  1  sticky; set when a request is served from an empty pool.
- fail_clr  in  1  clears underflow and health_fail, 1-cycle pulse.
- health_fail  out  1  sticky repetition-count failure; tied 0 without the feature.

Behaviour:
- Reset is asynchronous and active-high. While reset is asserted:
  - the synchroniser, divider, debiaser and pool are all cleared;
  - trng_bit, trng_avail, pool_count, underflow and health_fail are all 0.
- Synchroniser: SYNC_STAGES-flop chain on raw_bit. Its output is s_bit.
- Divider: a counter runs 0..SAMPLE_DIV-1. A sample strobe fires when the counter wraps to 0. With SAMPLE_DIV=1 the strobe fires every cycle.
- Debiaser FSM (2 states):
  - FIRST: on strobe, latch a=s_bit and go to SECOND.
  - SECOND: on strobe, with b=s_bit:
    - if a≠b, emit bit a (push request);
    - always return to FIRST.
  - Without a strobe, the FSM holds its state.
- Pool:
  - FIFO of bits. Push at tail, pop at head. trng_bit = head, combinational from registers.
  - Push with count=POOL_DEPTH and no same-cycle pop: bit dropped, count unchanged.
- Pop:
  - Pops on the rising edge of trng_req (req_q registered; pop = trng_req & ~req_q). A held request pops exactly once.
  - The bit returned in the same cycle as trng_req rises is the pre-pop head.
  - Pop with count=0: no state change to the pool, trng_bit=0, underflow set.
- Simultaneous push and pop:
  - count unchanged; the head advances and the new bit enters the tail.
  - Allowed when full. When empty, the pushed bit is not returned in that cycle and count becomes 1.
- trng_avail = (count≠0) & ~health_fail.
- fail_clr clears the sticky flags only. It does not flush the pool. If a set condition occurs in the same cycle, set wins.
- Wrap-around:
  - Read and write pointers are $clog2(POOL_DEPTH) bits and wrap naturally.
  - count is one bit wider and never exceeds POOL_DEPTH.

Optional Feature:
- Macro: TRNG_HEALTH_EN.
- With the macro defined:
  - A repetition-count test runs on each strobed sample. A run counter resets to 1 when s_bit differs from the previous sample and increments otherwise, saturating at RCT_CUTOFF.
  - When the counter reaches RCT_CUTOFF, health_fail is set (sticky).
  - While health_fail=1: the pool is flushed to count=0, pushes are suppressed, the debiaser is held in FIRST, and trng_bit=0.
  - fail_clr resumes operation with the run counter at 0.
- Without the macro: no run counter; health_fail is constant 0; RCT_CUTOFF is unused.

Decomposition:
- Package trng_pkg holds:
  - debiaser state enum (ST_FIRST, ST_SECOND);
  - default constants for POOL_DEPTH, SAMPLE_DIV and RCT_CUTOFF;
  - function for the count width.
- One sub-module, trng_bit_pool: parameterised single-bit FIFO with push, pop, flush, head, count. The debiaser, divider and health test stay in the top module.

Test Plan:
- Reset deasserted, SAMPLE_DIV=1, raw pairs 01,10,00,11,01 after sync → pool receives 0,1,0; pool_count=3; trng_avail=1.
- Pool at 16, more valid pairs arriving → pool_count stays 16, oldest bit still at head, no underflow.
- trng_req held 5 cycles with pool_count=3 → exactly one pop; pool_count=2; trng_bit during the rise cycle equals the previous head.
- Empty pool, trng_req pulse → trng_bit=0, underflow=1 sticky. Then fail_clr pulse → underflow=0.
- Push and pop in the same cycle at count=16 and at count=0 → count 16→16 and 0→1, respectively.
- With TRNG_HEALTH_EN, RCT_CUTOFF=32, raw_bit stuck at 1 for 32 samples → health_fail=1, pool_count=0, trng_avail=0. Then fail_clr plus toggling input → debiased bits resume.
- Reset asserted mid-pair with pool_count=5 → all outputs 0 immediately (asynchronous), FSM returns to FIRST.
